mem_a_stream: RTL and testbench
===============================

MEM_A_STREAM -- requirements
Module: mem_a_stream

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, signed element width.
REQ-002 SHALL have parameter DIM, default 8, matrix dimension, lane count and skew span; legal range 2..64.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port en, input, 1, advance enable; low freezes all sequential state except writes.
REQ-006 SHALL have port wr_en, input, 1, element write strobe.
REQ-007 SHALL have ports wr_row and wr_col, input, $clog2(DIM) each, write address.
REQ-008 SHALL have port wr_data, input signed, BITS_AB, write element.
REQ-009 SHALL have port start, input, 1, stream request.
REQ-010 SHALL have port transpose, input, 1, readout mode, sampled with start.
REQ-011 SHALL have port a_out, output signed, DIM x BITS_AB unpacked, skewed lane data.
REQ-012 SHALL have port lane_valid, output, DIM, per-lane data-valid.
REQ-013 SHALL have port busy, output, 1, high outside IDLE.
REQ-014 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-015 SHALL hold a DIM x DIM element store; a write in IDLE with wr_en high sets A[wr_row][wr_col]=wr_data at the clock edge, regardless of en.
REQ-016 SHALL ignore wr_en while busy is high; store is unchanged.
REQ-017 SHALL implement FSM IDLE -> STREAM -> DRAIN -> IDLE.
REQ-018 SHALL leave IDLE on start high, latching transpose; start while busy is ignored.
REQ-019 SHALL make a write and start in the same IDLE cycle commit the write first, so it is visible to the stream.
REQ-020 SHALL in STREAM, on each en-high cycle k=0..DIM-1, inject into lane i the element A[i][k] (transpose=0) or A[k][i] (transpose=1), then enter DRAIN after k=DIM-1.
REQ-021 SHALL delay lane i by exactly i advancing cycles plus one output register; lane 0 has no skew delay.
REQ-022 SHALL, with S0 as the first advancing STREAM cycle, present lane i element k at advancing cycle S0+1+i+k.
REQ-023 SHALL drive lane_valid[i] high exactly while a_out[i] carries a real element, otherwise a_out[i]=0.
REQ-024 SHALL stay in DRAIN DIM-1 advancing cycles, injecting zeros, then pulse done in the cycle the last element (lane DIM-1, k=DIM-1) is presented, returning to IDLE the next cycle.
REQ-025 SHALL, when en is low, hold a_out, lane_valid, counters and FSM state; a done pulse is held for the stalled cycles, then cleared after the next advancing edge.
REQ-026 SHALL use a counter of width $clog2(DIM)+1 with no wrap; terminal count DIM-1 per phase.

Reset
REQ-027 SHALL on rst force IDLE, counters 0, a_out all 0, lane_valid 0, busy 0, done 0, all skew stages 0.
REQ-028 SHALL clear the element store to 0 on rst.
REQ-029 SHALL, on rst mid-stream, abort with no done pulse; reset overrides en, wr_en and start in the same cycle.

Structure
REQ-030 SHALL put the FSM state enum and BITS_AB/DIM defaults in shared package mem_a_pkg.
REQ-031 SHALL implement skew using sub-module skew_delay_line (parametrised depth, width, enable-gated shift register carrying data plus valid bit), instantiated for lanes 1..DIM-1.

Verification
REQ-032 SHALL cover DIM=4, A[i][j]=4i+j, start with transpose=0, en=1 -> lane 2 shows 8,9,10,11 at S0+3..S0+6; done at S0+7; busy low at S0+8.
REQ-033 SHALL cover the same load with transpose=1 -> lane 1 shows 1,5,9,13 at S0+2..S0+5.
REQ-034 SHALL cover en low for 3 cycles mid-STREAM -> outputs frozen, sequence resumes intact, done delayed by exactly 3 cycles.
REQ-035 SHALL cover wr_en with A[0][0]=-7 during STREAM -> ignored; a rerun shows the old A[0][0]=0; a write plus start in the same IDLE cycle -> -7 appears on lane 0 at S0+1.
REQ-036 SHALL cover rst asserted at S0+3 -> next cycle all outputs 0, IDLE, store zero, no done pulse.
REQ-037 SHALL cover a start pulse during DRAIN -> no effect; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/mem_a_pkg.sv
// mem_a_pkg
// Shared definitions for the skewed matrix-A streamer: default element
// width and matrix dimension, plus the controller state encoding.
package mem_a_pkg;

   localparam int BITS_AB_DEF = 8;
   localparam int DIM_DEF     = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DRAIN  = 2'd2
   } state_t;

endpackage

// File: rtl/mem_a_stream_if.sv
// mem_a_stream_if
// Bundles the control, write and skewed-output signals of mem_a_stream.
//   en          advance enable (low freezes the stream, writes still land)
//   wr_en       element write strobe, honoured only while idle
//   wr_row/col  write address
//   wr_data     signed element to write
//   start       stream request, transpose sampled alongside it
//   a_out       per-lane skewed element data (zero when lane not valid)
//   lane_valid  per-lane data-valid
//   busy        high while a stream is in progress
//   done        one-cycle pulse when the last element is presented
// The master modport is the side that loads and kicks the streamer; the
// slave modport is the streamer itself.
interface mem_a_stream_if #(
   parameter int BITS_AB = mem_a_pkg::BITS_AB_DEF,
   parameter int DIM     = mem_a_pkg::DIM_DEF
);
   logic                      en;
   logic                      wr_en;
   logic [$clog2(DIM)-1:0]    wr_row;
   logic [$clog2(DIM)-1:0]    wr_col;
   logic signed [BITS_AB-1:0] wr_data;
   logic                      start;
   logic                      transpose;
   logic signed [BITS_AB-1:0] a_out [DIM];
   logic [DIM-1:0]            lane_valid;
   logic                      busy;
   logic                      done;

   modport master (
      output en, wr_en, wr_row, wr_col, wr_data, start, transpose,
      input  a_out, lane_valid, busy, done
   );

   modport slave (
      input  en, wr_en, wr_row, wr_col, wr_data, start, transpose,
      output a_out, lane_valid, busy, done
   );
endinterface

// File: rtl/skew_delay_line.sv
// skew_delay_line
// Enable-gated shift register of DEPTH stages carrying a data word plus
// its valid bit, used to stagger systolic lanes in time.
//   clk, rst     clock and synchronous active-high reset
//   en           shift enable; low holds every stage
//   din/din_valid   word and valid bit entering the line
//   dout/dout_valid word and valid bit leaving after DEPTH enabled edges
module skew_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid
);

   // Valid bit rides in the MSB so data and valid always move together.
   logic [WIDTH:0] stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < DEPTH; d++) begin
            stage[d] <= '0;
         end
      end else if (en) begin
         stage[0] <= {din_valid, din};
         for (int d = 1; d < DEPTH; d++) begin
            stage[d] <= stage[d-1];
         end
      end
   end

   assign dout       = stage[DEPTH-1][WIDTH-1:0];
   assign dout_valid = stage[DEPTH-1][WIDTH];

endmodule

// File: rtl/mem_a_stream.sv
// mem_a_stream
// Holds a DIM x DIM signed element store and streams it out as DIM skewed
// lanes for a systolic array. Lane i carries row i (or column i when
// transposed), delayed by i advancing cycles plus one output register, so
// lane i element k appears at advancing cycle S0+1+i+k.
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset (clears FSM, pipeline and store)
//   bus   mem_a_stream_if slave: en, write port, start/transpose,
//         a_out, lane_valid, busy, done
module mem_a_stream
   import mem_a_pkg::*;
#(
   parameter int BITS_AB = BITS_AB_DEF,
   parameter int DIM     = DIM_DEF
) (
   input  logic         clk,
   input  logic         rst,
   mem_a_stream_if.slave bus
);

   localparam int IW = $clog2(DIM);
   localparam int CW = IW + 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(DIM - 1);
   localparam logic [CW-1:0] DONE_CNT  = CW'(DIM - 2);

   state_t                    state;
   logic [CW-1:0]             cnt;
   logic                      tr_q;
   logic                      busy_q;
   logic                      done_q;
   logic [IW-1:0]             k_idx;

   logic signed [BITS_AB-1:0] store    [DIM][DIM];
   logic signed [BITS_AB-1:0] inj_data [DIM];
   logic [DIM-1:0]            inj_valid;
   logic [BITS_AB-1:0]        sk_data  [DIM];
   logic [DIM-1:0]            sk_valid;
   logic signed [BITS_AB-1:0] a_q      [DIM];
   logic [DIM-1:0]            v_q;

   // Element store. Writes are only accepted while idle (busy low), and
   // they do not depend on en so the store can be loaded with the stream
   // frozen. A write in the same cycle as start lands before STREAM reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
               store[r][c] <= '0;
            end
         end
      end else if (state == ST_IDLE && bus.wr_en) begin
         store[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end
   end

   // Controller: IDLE -> STREAM (DIM injecting cycles) -> DRAIN (DIM cycles,
   // zeros injected) -> IDLE. done is raised on the edge that makes the
   // last lane's last element visible, i.e. it covers the final DRAIN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         tr_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else if (bus.en) begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state  <= ST_STREAM;
                  cnt    <= '0;
                  tr_q   <= bus.transpose;
                  busy_q <= 1'b1;
               end
            end
            ST_STREAM: begin
               if (cnt == LAST_CNT) begin
                  state <= ST_DRAIN;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DRAIN: begin
               if (cnt == LAST_CNT) begin
                  state  <= ST_IDLE;
                  cnt    <= '0;
                  busy_q <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
                  if (cnt == DONE_CNT) begin
                     done_q <= 1'b1;
                  end
               end
            end
            default: begin
               state  <= ST_IDLE;
               cnt    <= '0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign k_idx = cnt[IW-1:0];

   // Injection: during STREAM, lane i receives column k of row i, or row k
   // of column i when transposed. Everything else injects zero/not-valid.
   always_comb begin
      inj_valid = (state == ST_STREAM) ? '1 : '0;
      for (int i = 0; i < DIM; i++) begin
         inj_data[i] = '0;
         if (state == ST_STREAM) begin
            inj_data[i] = tr_q ? store[k_idx][i] : store[i][k_idx];
         end
      end
   end

   // Lane 0 has no skew; lanes 1..DIM-1 get a delay line of depth i.
   assign sk_data[0]  = inj_data[0];
   assign sk_valid[0] = inj_valid[0];

   for (genvar g = 1; g < DIM; g++) begin : g_skew
      skew_delay_line #(
         .DEPTH (g),
         .WIDTH (BITS_AB)
      ) u_skew (
         .clk        (clk),
         .rst        (rst),
         .en         (bus.en),
         .din        (inj_data[g]),
         .din_valid  (inj_valid[g]),
         .dout       (sk_data[g]),
         .dout_valid (sk_valid[g])
      );
   end

   // Output register; data is forced to zero on lanes without a real
   // element so consumers can rely on a_out alone if they wish.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DIM; i++) begin
            a_q[i] <= '0;
         end
         v_q <= '0;
      end else if (bus.en) begin
         for (int i = 0; i < DIM; i++) begin
            a_q[i] <= sk_valid[i] ? signed'(sk_data[i]) : '0;
         end
         v_q <= sk_valid;
      end
   end

   assign bus.a_out      = a_q;
   assign bus.lane_valid = v_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;

endmodule

// File: tb/tb_mem_a_stream.sv
// tb_mem_a_stream
// Self-checking bench for mem_a_stream at DIM=4, BITS_AB=8. A hand-computed
// vector table covers the plain row-major stream; directed sequences cover
// transpose, stalls, writes while busy, write-with-start, start in DRAIN
// and reset mid-stream, checked against a small lane-timing model.
module tb_mem_a_stream;

   localparam int BITS_AB = 8;
   localparam int DIM     = 4;

   logic clk;
   logic rst;

   int tests;
   int failures;
   int a_model [DIM][DIM];

   typedef struct {
      logic [DIM-1:0] valid;
      logic [31:0]    data;    // lane i in bits [8i+7:8i]
      bit             done;
      bit             busy;
   } vec_t;

   vec_t vecs [2*DIM+1];

   mem_a_stream_if #(.BITS_AB(BITS_AB), .DIM(DIM)) bus ();

   mem_a_stream #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkEq(input string name, input logic signed [31:0] actual,
                          input logic signed [31:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Drive one cycle's inputs, then advance past the next rising edge.
   task automatic applyStimulus(input bit en, input bit start, input bit tr,
                                input bit wr, input int row, input int col,
                                input int data);
      bus.en        = en;
      bus.start     = start;
      bus.transpose = tr;
      bus.wr_en     = wr;
      bus.wr_row    = 2'(row);
      bus.wr_col    = 2'(col);
      bus.wr_data   = 8'(data);
      step();
   endtask

   // Compare all outputs against the model after t advancing cycles from S0.
   task automatic checkOutput(input string tag, input bit tr, input int t);
      int k;
      int exp_d;
      bit exp_v;
      for (int i = 0; i < DIM; i++) begin
         k = t - 1 - i;
         exp_v = (k >= 0) && (k < DIM);
         exp_d = exp_v ? (tr ? a_model[k][i] : a_model[i][k]) : 0;
         checkEq($sformatf("%s t=%0d lane%0d valid", tag, t, i),
                 {31'b0, bus.lane_valid[i]}, {31'b0, exp_v});
         checkEq($sformatf("%s t=%0d lane%0d data", tag, t, i),
                 bus.a_out[i], exp_d);
      end
      checkEq($sformatf("%s t=%0d done", tag, t), {31'b0, bus.done},
              (t == 2*DIM-1) ? 1 : 0);
      checkEq($sformatf("%s t=%0d busy", tag, t), {31'b0, bus.busy},
              (t <= 2*DIM-1) ? 1 : 0);
   endtask

   // One complete stream with optional stall, write-while-busy,
   // write-with-start and start-during-DRAIN disturbances.
   task automatic runStream(input string tag, input bit tr, input int stall_t,
                            input int stall_n, input bit wr_mid,
                            input bit wr_start, input bit drain_start);
      int t;
      int stalled;
      int cyc;
      int done_cnt;
      int done_cyc;
      bit en_n;
      bit st_n;
      bit wr_n;
      if (wr_start) begin
         a_model[0][0] = -7;
      end
      applyStimulus(1'b1, 1'b1, tr, wr_start, 0, 0, -7);
      t = 0; stalled = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
      while (cyc < 60) begin
         checkOutput(tag, tr, t);
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
         end
         if (t == 2*DIM) break;
         wr_n = wr_mid && (t == 1);
         st_n = drain_start && (t == DIM + 1);
         if (t == stall_t && stalled < stall_n) begin
            en_n = 1'b0;
            stalled++;
         end else begin
            en_n = 1'b1;
            t++;
         end
         // transpose is toggled away from its start value to prove it was latched
         applyStimulus(en_n, st_n, ~tr, wr_n, 0, 0, -7);
         cyc++;
      end
      checkEq({tag, " reached end"}, t, 2*DIM);
      checkEq({tag, " done pulses"}, done_cnt, 1);
      checkEq({tag, " done cycle"}, done_cyc, 2*DIM-1+stall_n);
      for (int n = 0; n < 2; n++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
         checkEq({tag, " idle busy"}, {31'b0, bus.busy}, 0);
         checkEq({tag, " idle done"}, {31'b0, bus.done}, 0);
      end
   endtask

   initial begin
      int done_seen;
      logic signed [7:0] exp_b;
      tests = 0;
      failures = 0;

      // Hand-computed stream for A[i][j] = 4i+j, transpose=0.
      vecs[0] = '{4'b0000, 32'h00000000, 1'b0, 1'b1};
      vecs[1] = '{4'b0001, 32'h00000000, 1'b0, 1'b1};
      vecs[2] = '{4'b0011, 32'h00000401, 1'b0, 1'b1};
      vecs[3] = '{4'b0111, 32'h00080502, 1'b0, 1'b1};
      vecs[4] = '{4'b1111, 32'h0C090603, 1'b0, 1'b1};
      vecs[5] = '{4'b1110, 32'h0D0A0700, 1'b0, 1'b1};
      vecs[6] = '{4'b1100, 32'h0E0B0000, 1'b0, 1'b1};
      vecs[7] = '{4'b1000, 32'h0F000000, 1'b1, 1'b1};
      vecs[8] = '{4'b0000, 32'h00000000, 1'b0, 1'b0};

      // Reset overrides start and writes.
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 5);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 5);
      rst = 1'b0;
      for (int i = 0; i < DIM; i++) begin
         checkEq($sformatf("reset lane%0d data", i), bus.a_out[i], 0);
      end
      checkEq("reset lane_valid", {28'b0, bus.lane_valid}, 0);
      checkEq("reset busy", {31'b0, bus.busy}, 0);
      checkEq("reset done", {31'b0, bus.done}, 0);

      // Load A[i][j] = 4i+j; first two rows with en low.
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) begin
            a_model[i][j] = 4*i + j;
            applyStimulus(i >= 2, 1'b0, 1'b0, 1'b1, i, j, 4*i + j);
         end
      end

      // Table-driven row-major stream.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
      for (int t = 0; t <= 2*DIM; t++) begin
         for (int i = 0; i < DIM; i++) begin
            exp_b = vecs[t].data[8*i +: 8];
            checkEq($sformatf("table t=%0d lane%0d data", t, i), bus.a_out[i], exp_b);
         end
         checkEq($sformatf("table t=%0d lane_valid", t), {28'b0, bus.lane_valid},
                 {28'b0, vecs[t].valid});
         checkEq($sformatf("table t=%0d done", t), {31'b0, bus.done}, {31'b0, vecs[t].done});
         checkEq($sformatf("table t=%0d busy", t), {31'b0, bus.busy}, {31'b0, vecs[t].busy});
         if (t < 2*DIM) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      end

      runStream("transpose", 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
      runStream("stall", 1'b0, 2, 3, 1'b0, 1'b0, 1'b0);
      runStream("wr_busy", 1'b0, -1, 0, 1'b1, 1'b0, 1'b0);
      runStream("rerun", 1'b0, -1, 0, 1'b0, 1'b0, 1'b0);
      runStream("wr_start", 1'b0, -1, 0, 1'b0, 1'b1, 1'b0);
      runStream("drain_start", 1'b1, -1, 0, 1'b0, 1'b0, 1'b1);

      // Reset at S0+3 with start and a write asserted alongside it.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
      for (int n = 0; n < 3; n++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
      rst = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1, 1, 5);
      rst = 1'b0;
      for (int i = 0; i < DIM; i++) begin
         checkEq($sformatf("midrst lane%0d data", i), bus.a_out[i], 0);
      end
      checkEq("midrst lane_valid", {28'b0, bus.lane_valid}, 0);
      checkEq("midrst busy", {31'b0, bus.busy}, 0);
      checkEq("midrst done", {31'b0, bus.done}, 0);
      done_seen = 0;
      for (int n = 0; n < 3*DIM; n++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
         if (bus.done === 1'b1) done_seen++;
      end
      checkEq("midrst no done", done_seen, 0);
      checkEq("midrst stays idle", {31'b0, bus.busy}, 0);
      for (int i = 0; i < DIM; i++) begin
         for (int j = 0; j < DIM; j++) a_model[i][j] = 0;
      end
      runStream("post_rst", 1'b0, -1, 0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
